risky_fetch: RTL and testbench

Instruction fetch stage for the risky RV32I core; sits directly upstream of decode.
- Generates sequential PCs and issues word requests to instruction memory.
- Buffers returned instructions with their PCs in a small in-order queue.
- Presents instructions to decode via a valid/ready handshake.
- Branch/jump redirects flush queued and in-flight fetches.

---
 rtl/risky_fetch.sv | 132 +++++++++++++
 tb/tb_risky_fetch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/risky_fetch.sv
// Instruction fetch stage for the risky RV32I core: sequential PC generation,
// an in-order instruction queue toward decode, and redirect flush with stale-response dropping.
module risky_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int CW = $clog2(DEPTH + 1) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic [31:0] data_q [DEPTH];
  logic [31:0] data_d [DEPTH];
  logic [31:0] qpc_q [DEPTH];
  logic [31:0] qpc_d [DEPTH];
  ptr_t        rd_ptr_q, rd_ptr_d;
  cnt_t        count_q, count_d;
  cnt_t        out_q, out_d;
  cnt_t        drop_q, drop_d;

  logic        req_fire;
  logic        push;
  logic        pop;
  cnt_t        wr_sum;
  ptr_t        wr_idx;
  logic [31:0] redir_aligned;

  // Handshake decode, queue bookkeeping and next-state for every counter and PC.
  always_comb begin
    // rst_n gates the request so it drops asynchronously with the rest of the state.
    imem_req_valid = rst_n && !redirect_valid && ((out_q + count_q) < cnt_t'(DEPTH));
    imem_req_addr  = fetch_pc_q;
    inst_valid     = (count_q != cnt_t'(0));
    inst_data      = inst_valid ? data_q[rd_ptr_q] : 32'h0000_0000;
    inst_pc        = inst_valid ? qpc_q[rd_ptr_q] : 32'h0000_0000;

    req_fire      = imem_req_valid && imem_req_ready;
    pop           = inst_valid && inst_ready;
    push          = imem_resp_valid && !redirect_valid && (drop_q == cnt_t'(0));
    redir_aligned = {redirect_pc[31:2], 2'b00};

    wr_sum = cnt_t'(rd_ptr_q) + count_q;
    wr_sum = (wr_sum >= cnt_t'(DEPTH)) ? (wr_sum - cnt_t'(DEPTH)) : wr_sum;
    wr_idx = wr_sum[PW-1:0];

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    data_d     = data_q;
    qpc_d      = qpc_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + cnt_t'(push) - cnt_t'(pop);
    out_d      = out_q + cnt_t'(req_fire) - cnt_t'(imem_resp_valid);
    drop_d     = drop_q;

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end

    if (push) begin
      data_d[wr_idx] = imem_resp_data;
      qpc_d[wr_idx]  = resp_pc_q;
      resp_pc_d      = resp_pc_q + 32'd4;
    end else begin
      resp_pc_d = resp_pc_q;
    end

    if (pop) begin
      rd_ptr_d = (rd_ptr_q == ptr_t'(DEPTH - 1)) ? ptr_t'(0) : (rd_ptr_q + ptr_t'(1));
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // After a redirect every request still in flight is stale, including ones already
    // marked for dropping, so the drop count becomes exactly the remaining in-flight total.
    if (redirect_valid) begin
      fetch_pc_d = redir_aligned;
      resp_pc_d  = redir_aligned;
      rd_ptr_d   = ptr_t'(0);
      count_d    = cnt_t'(0);
      drop_d     = out_q - cnt_t'(imem_resp_valid);
    end else if (imem_resp_valid && (drop_q != cnt_t'(0))) begin
      drop_d = drop_q - cnt_t'(1);
    end else begin
      drop_d = drop_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      rd_ptr_q   <= ptr_t'(0);
      count_q    <= cnt_t'(0);
      out_q      <= cnt_t'(0);
      drop_q     <= cnt_t'(0);
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= 32'h0000_0000;
        qpc_q[i]  <= 32'h0000_0000;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      data_q     <= data_d;
      qpc_q      <= qpc_d;
    end
  end

endmodule

// File: tb/tb_risky_fetch.sv
// Bench for risky_fetch: directed vector table, async reset check, and a randomized
// run against an epoch-tagged reference model of the fetch stream.
module tb_risky_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  risky_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } mreq_t;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    int          lat;
    logic        e_rv;
    logic [31:0] e_ra;
    logic        e_iv;
    logic [31:0] e_ipc;
  } row_t;

  mreq_t       mq[$];
  row_t        rows[$];
  int          cyc = 0;
  int          last_due = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          epoch = 0;
  logic [31:0] dmask = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic add(input logic rst, input logic rdy, input logic redir, input logic [31:0] rpc,
                     input int lat, input logic erv, input logic [31:0] era,
                     input logic eiv, input logic [31:0] eipc);
    row_t r;
    r.rst = rst; r.rdy = rdy; r.redir = redir; r.rpc = rpc; r.lat = lat;
    r.e_rv = erv; r.e_ra = era; r.e_iv = eiv; r.e_ipc = eipc;
    rows.push_back(r);
  endtask

  // Called at a negedge: apply inputs, present the next due memory response, let logic settle.
  task automatic drive(input logic rdy, input logic redir, input logic [31:0] rpc, input logic qrdy);
    inst_ready     = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = qrdy;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mq[0].addr ^ dmask;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'hDEAD_BEEF;
    end
    #1;
  endtask

  task automatic advance(input int lat);
    int d;
    if (imem_req_valid && imem_req_ready) begin
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq.push_back('{imem_req_addr, d, epoch});
    end
    if (imem_resp_valid) void'(mq.pop_front());
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    mq.delete();
    #1;
    chk("rst_req_valid", imem_req_valid, 32'd0);
    chk("rst_inst_valid", inst_valid, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_due = cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic        redir, rdy, qrdy, fire, pop, good;
    logic [31:0] rpc, exp_fetch, exp_dec;
    int          lat, mcount, dec;

    rst_n = 1'b0;
    // Sequential fetch, 1-cycle memory, decode always ready.
    add(1,1,0,0,1, 1,32'h0,0,32'h0);
    add(0,1,0,0,1, 1,32'h4,0,32'h0);
    add(0,1,0,0,1, 0,32'h0,1,32'h0);
    add(0,1,0,0,1, 1,32'h8,1,32'h4);
    add(0,1,0,0,1, 1,32'hC,0,32'h0);
    add(0,1,0,0,1, 0,32'h0,1,32'h8);
    add(0,1,0,0,1, 1,32'h10,1,32'hC);
    add(0,1,0,0,1, 1,32'h14,0,32'h0);
    // Decode stalled: only two requests issue until a pop frees space.
    add(1,0,0,0,1, 1,32'h0,0,32'h0);
    add(0,0,0,0,1, 1,32'h4,0,32'h0);
    add(0,0,0,0,1, 0,32'h0,1,32'h0);
    add(0,0,0,0,1, 0,32'h0,1,32'h0);
    add(0,1,0,0,1, 0,32'h0,1,32'h0);
    add(0,1,0,0,1, 1,32'h8,1,32'h4);
    add(0,1,0,0,1, 1,32'hC,0,32'h0);
    // Redirect with 0x8 and 0xC in flight; both responses must be dropped.
    add(1,1,0,0,3, 1,32'h0,0,32'h0);
    add(0,1,0,0,3, 1,32'h4,0,32'h0);
    add(0,1,0,0,3, 0,32'h0,0,32'h0);
    add(0,1,0,0,3, 0,32'h0,0,32'h0);
    add(0,1,0,0,3, 0,32'h0,1,32'h0);
    add(0,1,0,0,3, 1,32'h8,1,32'h4);
    add(0,1,0,0,3, 1,32'hC,0,32'h0);
    add(0,1,1,32'h103,3, 0,32'h0,0,32'h0);
    add(0,1,0,0,3, 0,32'h0,0,32'h0);
    add(0,1,0,0,3, 1,32'h100,0,32'h0);
    add(0,1,0,0,3, 1,32'h104,0,32'h0);
    add(0,1,0,0,3, 0,32'h0,0,32'h0);
    add(0,1,0,0,3, 0,32'h0,0,32'h0);
    add(0,1,0,0,3, 0,32'h0,1,32'h100);
    add(0,1,0,0,3, 1,32'h108,1,32'h104);
    // Redirect coinciding with a response and a decode handshake; target wraps past 2^32.
    add(1,1,0,0,2, 1,32'h0,0,32'h0);
    add(0,1,0,0,2, 1,32'h4,0,32'h0);
    add(0,1,0,0,2, 0,32'h0,0,32'h0);
    add(0,1,1,32'hFFFF_FFFE,2, 0,32'h0,1,32'h0);
    add(0,1,0,0,2, 1,32'hFFFF_FFFC,0,32'h0);
    add(0,1,0,0,2, 1,32'h0,0,32'h0);
    add(0,1,0,0,2, 0,32'h0,0,32'h0);
    add(0,1,0,0,2, 0,32'h0,1,32'hFFFF_FFFC);
    add(0,1,0,0,2, 1,32'h4,1,32'h0);

    dmask = 32'h0;
    for (int i = 0; i < rows.size(); i++) begin
      if (rows[i].rst) do_reset();
      drive(rows[i].rdy, rows[i].redir, rows[i].rpc, 1'b1);
      chk($sformatf("vec%0d_req_valid", i), imem_req_valid, rows[i].e_rv);
      if (rows[i].e_rv) chk($sformatf("vec%0d_req_addr", i), imem_req_addr, rows[i].e_ra);
      chk($sformatf("vec%0d_inst_valid", i), inst_valid, rows[i].e_iv);
      chk($sformatf("vec%0d_inst_pc", i), inst_pc, rows[i].e_ipc);
      chk($sformatf("vec%0d_inst_data", i), inst_data, rows[i].e_ipc);
      advance(rows[i].lat);
    end

    // Fill the queue, then pull reset between clock edges.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      advance(1);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("full_inst_valid", inst_valid, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_inst_valid", inst_valid, 32'd0);
    chk("async_req_valid", imem_req_valid, 32'd0);
    chk("async_inst_pc", inst_pc, 32'd0);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    last_due = cyc;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("post_rst_req_valid", imem_req_valid, 32'd1);
    chk("post_rst_req_addr", imem_req_addr, 32'h0);

    // Randomized run against the epoch-tagged stream model.
    do_reset();
    dmask = 32'h5A5A_0000;
    exp_fetch = 32'h0; exp_dec = 32'h0; mcount = 0; epoch = 0; dec = 0;
    for (int i = 0; i < 4000 && dec < 150; i++) begin
      redir = ($urandom_range(0, 19) == 0);
      rpc   = $urandom;
      rdy   = ($urandom_range(0, 3) != 0);
      qrdy  = $urandom_range(0, 1);
      lat   = $urandom_range(1, 4);
      drive(rdy, redir, rpc, qrdy);
      chk("rnd_req_valid", imem_req_valid, (!redir && (mq.size() + mcount < 2)));
      chk("rnd_inst_valid", inst_valid, (mcount != 0));
      fire = imem_req_valid && qrdy;
      if (fire) begin
        chk("rnd_req_addr", imem_req_addr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end
      pop = 1'b0;
      if (inst_valid) begin
        chk("rnd_inst_pc", inst_pc, exp_dec);
        chk("rnd_inst_data", inst_data, exp_dec ^ dmask);
        if (rdy) begin
          exp_dec = exp_dec + 32'd4;
          dec++;
          pop = 1'b1;
        end
      end else begin
        chk("rnd_idle_pc", inst_pc, 32'h0);
      end
      good = imem_resp_valid && !redir && (mq.size() > 0) && (mq[0].ep == epoch);
      mcount = mcount + int'(good) - int'(pop);
      if (redir) begin
        exp_fetch = {rpc[31:2], 2'b00};
        exp_dec   = {rpc[31:2], 2'b00};
        epoch++;
        mcount = 0;
      end
      advance(lat);
    end
    chk("rnd_progress", (dec >= 150), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
